mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit, the sequential successor to the single-cycle ALU, parametrised in WIDTH.
- Executes MULT, MULTU, DIV and DIVU, and holds the results in HI/LO registers that serve MFHI/MFLO.
- Sits beside the ALU in the execute stage. The controller stalls on busy.
- Uses a radix-2 shift-add multiplier and a restoring divider, one bit per cycle.

Parameters:
- WIDTH, default 32: operand and HI/LO width. Must be at least 2.
- CNT_W, default $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- in0  in  WIDTH  multiplicand or dividend.
- in1  in  WIDTH  multiplier or divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi/lo are updated in the same cycle.
- div_by_zero  out  1  one-cycle pulse coincident with done when a divide had in1 == 0.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.

Behaviour:
- Reset: state IDLE. busy, done, div_by_zero, hi, lo and all internal registers are 0. Reset mid-operation aborts it; no done follows.
- States: IDLE -> CALC -> FIXUP -> IDLE.
- IDLE:
  - If start = 1, latch op.
  - For signed ops, latch operand magnitudes plus the sign flags: sign(in0)^sign(in1) for the product/quotient, sign(in0) for the remainder.
  - Latch the div-by-zero flag (divide op and in1 == 0).
  - Clear the counter and accumulator, then go to CALC.
- CALC, exactly WIDTH cycles:
  - Multiply: if the multiplier LSB is set, add the multiplicand into the 2*WIDTH accumulator upper half (with carry), then shift right 1.
  - Divide: shift {rem, quo} left 1; trial-subtract the divisor; if the result is non-negative, commit it and set the quotient LSB.
  - When the counter reaches WIDTH-1, go to FIXUP.
- FIXUP, 1 cycle:
  - Negate the product (2*WIDTH two's complement) or the quotient/remainder per the latched sign flags. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - On this cycle's edge, write hi/lo, pulse done (and div_by_zero when flagged), and return to IDLE.
- Latency: start is accepted in cycle 0; done is high in cycle WIDTH+2 (34 for WIDTH=32).
- busy = 1 in CALC and FIXUP; 0 in IDLE, including the done cycle.
- Back-to-back: start may be asserted during the done cycle and is accepted.
- start while busy is ignored; the in-flight op is unaffected.
- in0, in1 and op are sampled only at acceptance; later changes have no effect.
- Divide by zero: same latency. Result is hi = original in0 and lo = all ones, for both signed and unsigned; sign fixup is skipped.
- Overflow: DIV of the most-negative value by -1 gives lo = most-negative and hi = 0 (natural WIDTH-bit wrap). No flag.
- Outside the done edge, hi and lo hold their values; no writes occur while busy.

Decomposition:
- Package mdu_pkg holds:
  - typedef mdu_op_t: MULTU, MULT, DIVU, DIV.
  - typedef mdu_state_t: IDLE, CALC, FIXUP.
  - Op encoding constants.
- One natural sub-module, mdu_negate #(N): conditional two's-complement negate, used for operand magnitudes and result fixup. Everything else lives in mul_div_unit.

Test Plan:
- MULTU in0 = in1 = 0xFFFFFFFF -> done in cycle 34; hi = 0xFFFFFFFE, lo = 0x00000001; busy high in cycles 1-33.
- MULT -3 x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 7 -> lo = 14, hi = 2. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 5 / 0 -> hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1 for exactly one cycle, coincident with done.
- Start MULTU 6 x 7:
  - Pulse start with DIVU 9 / 3 at cycle 5; it is ignored.
  - Result hi = 0, lo = 42.
  - Start DIVU 9 / 3 in the done cycle; it is accepted, giving lo = 3, hi = 0 exactly 34 cycles later.
- Start MULTU, then assert rst at cycle 10 -> next cycle busy = 0, hi = lo = 0, and no done pulse ever follows. A new start after reset completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state types and helpers for the multiply/divide unit
package mdu_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  typedef enum logic [1:0] {
    MULTU = OP_MULTU,
    MULT  = OP_MULT,
    DIVU  = OP_DIVU,
    DIV   = OP_DIV
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} mdu_state_t;
  function automatic logic is_div(input mdu_op_t o);
    return o == DIVU || o == DIV;
  endfunction
  function automatic logic is_signed(input mdu_op_t o);
    return o == MULT || o == DIV;
  endfunction
endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negate
module mdu_negate #(
  parameter int N = 32
) (
  input  logic         en,
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = en ? -a : a;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider with HI/LO results
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_t state;
  mdu_op_t op_r;
  logic neg_q, neg_r, dbz;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] b;
  mdu_op_t op_i;
  logic s0, s1, dz;
  logic [WIDTH-1:0] mag0, mag1, quo_f, rem_f;
  logic [2*WIDTH-1:0] prod_f, mul_nxt, div_nxt;
  logic [WIDTH:0] sum, diff;
  assign op_i = mdu_op_t'(op);
  assign s0 = is_signed(op_i) & in0[WIDTH-1];
  assign s1 = is_signed(op_i) & in1[WIDTH-1];
  assign dz = is_div(op_i) & (in1 == '0);
  assign busy = state != IDLE;
  // a zero divisor keeps the raw dividend so the divider leaves it as the remainder
  mdu_negate #(.N(WIDTH)) u_mag0 (.en(s0 & ~dz), .a(in0), .y(mag0));
  mdu_negate #(.N(WIDTH)) u_mag1 (.en(s1), .a(in1), .y(mag1));
  mdu_negate #(.N(2*WIDTH)) u_prod (.en(neg_q), .a(acc), .y(prod_f));
  mdu_negate #(.N(WIDTH)) u_quo (.en(neg_q), .a(acc[WIDTH-1:0]), .y(quo_f));
  mdu_negate #(.N(WIDTH)) u_rem (.en(neg_r), .a(acc[2*WIDTH-1:WIDTH]), .y(rem_f));
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b};
  assign diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
  assign mul_nxt = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  assign div_nxt = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r <= MULTU;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz <= 1'b0;
      cnt <= '0;
      acc <= '0;
      b <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r <= op_i;
          neg_q <= (s0 ^ s1) & ~dz;
          neg_r <= s0 & ~dz;
          dbz <= dz;
          cnt <= '0;
          acc <= {{WIDTH{1'b0}}, mag0};
          b <= mag1;
          state <= CALC;
        end
        CALC: begin
          acc <= is_div(op_r) ? div_nxt : mul_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          {hi, lo} <= is_div(op_r) ? {rem_f, quo_f} : prod_f;
          done <= 1'b1;
          div_by_zero <= dbz;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] in0 = '0, in1 = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int errors = 0;
  int checks = 0;
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in0(in0), .in1(in1),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    longint sa = longint'($signed(a));
    longint sd = longint'($signed(d));
    longint unsigned ua = {32'b0, a};
    longint unsigned ud = {32'b0, d};
    if (o[1] && d == 0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'b00: return ua * ud;
      2'b01: return sa * sd;
      2'b10: return {32'(ua % ud), 32'(ua / ud)};
      default: return {32'(sa % sd), 32'(sa / sd)};
    endcase
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // called at a negedge with the unit idle (or in its done cycle); returns at the done-cycle negedge
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d, input int poke);
    logic [63:0] exp;
    int n;
    int bad;
    exp = model(o, a, d);
    n = 0;
    bad = 0;
    start = 1'b1; op = o; in0 = a; in1 = d;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        if (busy !== 1'b1 || div_by_zero !== 1'b0) bad++;
        if (n == poke) begin
          start = 1'b1; op = 2'b10; in0 = 32'd9; in1 = 32'd3;
        end else begin
          start = 1'($urandom_range(0, 1)); op = 2'($urandom); in0 = $urandom; in1 = $urandom;
        end
      end
    end while (done !== 1'b1 && n < 100);
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd34);
    chk({tag, " hilo"}, {hi, lo}, exp);
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(o[1] && d == 0));
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    chk({tag, " busy_flight"}, 64'(bad), 64'd0);
  endtask
  initial begin
    int dn;
    logic [1:0] ro;
    logic [31:0] ra, rd;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dbz", 64'(div_by_zero), 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_neg", 2'b01, -32'sd3, 32'd5, -1);
    chk("mult_neg exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("div_neg", 2'b11, -32'sd7, 32'd2, -1);
    chk("div_neg exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7, -1);
    chk("divu_100_7 exact", {hi, lo}, {32'd2, 32'd14});
    do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf exact", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op("div_neg_zero", 2'b11, -32'sd5, 32'd0, -1);
    do_op("divu_zero", 2'b10, 32'd5, 32'd0, -1);
    chk("divu_zero exact", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    @(negedge clk);
    chk("dbz one cycle", 64'(div_by_zero), 64'd0);
    chk("done one cycle", 64'(done), 64'd0);
    do_op("multu_6_7", 2'b00, 32'd6, 32'd7, 5);
    chk("multu_6_7 exact", {hi, lo}, 64'd42);
    do_op("divu_b2b", 2'b10, 32'd9, 32'd3, -1);
    chk("divu_b2b exact", {hi, lo}, 64'd3);
    @(negedge clk);
    start = 1'b1; op = 2'b00; in0 = $urandom; in1 = $urandom;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort no done", 64'(dn), 64'd0);
    do_op("after_rst", 2'b01, 32'd1234, -32'sd77, -1);
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 300)) : $urandom;
      rd = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 20)) : $urandom);
      do_op($sformatf("rand%0d", i), ro, ra, rd, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
